sysx_slave: RTL and testbench
=============================

SYSX_SLAVE -- requirements
Module: sysx_slave

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2: the number of synchronizer flops on iBusClock, iBusSelect and iBusMOSI (minimum 2).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 1024: the stall limit in iClock cycles, used only when the watchdog is compiled in.
REQ-003 iClock  input  1  local clock; the block has this single clock and all logic is on its rising edge.
REQ-004 iReset  input  1  asynchronous, active-low reset.
REQ-005 iBusClock  input  1  sysX serial clock from the master.
REQ-006 iBusSelect  input  1  sysX slave select, active-low.
REQ-007 iBusMOSI  input  8  master-to-slave byte lane.
REQ-008 oBusMISO  output  8  slave-to-master byte lane; high-impedance whenever the block is not selected.
REQ-009 oBusInterrupt  output  1  interrupt request to the master, active-high.
REQ-010 oLocalAddress  output  4  local register address.
REQ-011 oLocalWriteData  output  32  local write data.
REQ-012 oLocalWrite  output  1  one-cycle local write strobe.
REQ-013 oLocalRead  output  1  one-cycle local read strobe.
REQ-014 iLocalReadData  input  32  local read data, valid one iClock cycle after oLocalRead.
REQ-015 iLocalInterrupt  input  1  interrupt level from the device.
REQ-016 oTimeout  output  1  one-cycle pulse when the watchdog aborts a transaction.

Function
REQ-017 iBusClock, iBusSelect and iBusMOSI SHALL pass through SYNC_STAGES flops; bus-clock rising and falling edges are detected on the synchronized value.
REQ-018 iClock SHALL be at least 8x the iBusClock frequency; this is a usage requirement that the block does not check.
REQ-019 A transaction SHALL begin on the synchronized falling edge of iBusSelect.
REQ-020 The first MOSI byte SHALL be the command, captured on the bus-clock rising edge: bit7 = 1 for write, 0 for read; bits[3:0] = address; bits[6:4] are ignored.
REQ-021 The state machine SHALL have the states IDLE, CMD, WDATA, RFETCH, RDATA and DONE.
REQ-022 State transitions:
- IDLE->CMD on select assert.
- CMD->WDATA on a write command.
- CMD->RFETCH on a read command.
- WDATA->DONE after the 4th data byte.
- RFETCH->RDATA after the read data is captured.
- RDATA->DONE after the 4th byte has been shifted out.
- Any state->IDLE on select deassert.
REQ-023 Write: four data bytes SHALL be captured MSB first; oLocalWrite SHALL pulse for one cycle, exactly 1 cycle after the 4th byte's rising edge is detected, with the address and data held stable during the pulse.
REQ-024 Read: oLocalRead SHALL pulse 1 cycle after the command byte is captured, and iLocalReadData SHALL be latched on the following cycle.
REQ-025 Read output: byte 3 (MSB) SHALL drive oBusMISO from the first bus-clock falling edge after the capture, and each later falling edge SHALL advance one byte, ending with byte 0.
REQ-026 Master timing: the master samples MISO on the rising edge.
REQ-027 In DONE, extra bus bytes SHALL be ignored, oBusMISO SHALL drive 8'h00, and no local strobes SHALL be issued.
REQ-028 If select deasserts mid-transaction, the block SHALL:
- abort immediately;
- issue no oLocalWrite for a partial write;
- set oBusMISO to Z within SYNC_STAGES+1 cycles.
REQ-029 If select reasserts in the same cycle that DONE/abort returns to IDLE, the block SHALL start a new transaction (IDLE->CMD) without losing the first edge.
REQ-030 oBusInterrupt SHALL be iLocalInterrupt registered once (1-cycle latency), independent of the transaction state.
REQ-031 The byte counter SHALL be 2 bits, and its wrap from 3 to 0 SHALL coincide with the WDATA/RDATA exit.

Reset
REQ-032 While iReset is low, the block SHALL immediately hold:
- state = IDLE;
- oBusMISO = Z;
- oBusInterrupt, oLocalWrite, oLocalRead and oTimeout = 0;
- oLocalAddress = 0;
- oLocalWriteData = 0;
- all synchronizers = idle levels (clock 0, select 1, MOSI 0).
REQ-033 Release of iReset SHALL take effect on the next iClock edge; a reset mid-transaction SHALL discard the transaction with no strobe.

Configuration
REQ-034 When SYSX_SLAVE_TIMEOUT_EN is defined, a counter SHALL clear on every bus-clock edge and on deselect, and count iClock cycles while the block is selected and not in IDLE.
REQ-035 With SYSX_SLAVE_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES SHALL:
- pulse oTimeout for one cycle;
- move the block to DONE, so that no strobe is issued until the next select.
REQ-036 When SYSX_SLAVE_TIMEOUT_EN is undefined, there SHALL be no counter logic, oTimeout SHALL be tied to 0, and a stalled transaction SHALL wait indefinitely.

Verification
REQ-037 Write: command 8'h85, then bytes DE AD BE EF -> oLocalAddress=5, oLocalWriteData=32'hDEADBEEF, one oLocalWrite pulse.
REQ-038 Read: command 8'h03, iLocalReadData=32'h12345678 -> one oLocalRead pulse, with address 3; MISO bytes 12, 34, 56, 78; oBusMISO=Z after deselect.
REQ-039 Abort: write command 8'h81 with 2 data bytes, then deselect -> no oLocalWrite, state IDLE; the next full write to address 1 completes correctly.
REQ-040 Reset: iReset pulled low during RDATA -> outputs at reset values in the same cycle; after release, a new read works.
REQ-041 Interrupt/timeout: iLocalInterrupt 0->1 -> oBusInterrupt=1 one cycle later; with the macro and TIMEOUT_CYCLES=16, select held with no clock for 16 cycles -> one oTimeout pulse and no strobes.

Source files
------------

// File: rtl/sysx_slave_if.sv
// sysX serial bus between master and slave: the master drives clock, select and MOSI;
// the slave returns its interrupt request. MISO is a tri-state pad and stays a plain port.
interface sysx_slave_if;
  logic       iBusClock;
  logic       iBusSelect;
  logic [7:0] iBusMOSI;
  logic       oBusInterrupt;

  modport master (output iBusClock, output iBusSelect, output iBusMOSI, input oBusInterrupt);
  modport slave  (input iBusClock, input iBusSelect, input iBusMOSI, output oBusInterrupt);
endinterface

// File: rtl/sysx_slave.sv
// sysX serial slave: oversamples the bus on iClock and bridges 32-bit register reads/writes.
// Optional stall watchdog compiled in with `define SYSX_SLAVE_TIMEOUT_EN.
module sysx_slave #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        iClock,
  input  logic        iReset,
  sysx_slave_if.slave bus,
  output wire  [7:0]  oBusMISO,
  output logic [3:0]  oLocalAddress,
  output logic [31:0] oLocalWriteData,
  output logic        oLocalWrite,
  output logic        oLocalRead,
  input  logic [31:0] iLocalReadData,
  input  logic        iLocalInterrupt,
  output logic        oTimeout
);

  if (SYNC_STAGES < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("sysx_slave: SYNC_STAGES must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [2:0] {IDLE, CMD, WDATA, RFETCH, RDATA, DONE} state_t;

  state_t                      state, state_next;
  logic [SYNC_STAGES-1:0]      clk_sync, sel_sync;
  logic [SYNC_STAGES-1:0][7:0] mosi_sync;
  logic                        clk_prev, sel_prev;
  logic                        clk_s, sel_s;
  logic [7:0]                  mosi_s;
  logic                        clk_rise, clk_fall, sel_fall;
  logic [1:0]                  byte_cnt;
  logic [31:0]                 rdata;
  logic [7:0]                  miso_q, miso_val;
  logic                        wd_hit;

  // Synchronizers and edge-history flops reset to the bus idle levels.
  // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      clk_sync  <= '0;
      sel_sync  <= '1;
      mosi_sync <= '0;
      clk_prev  <= 1'b0;
      sel_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], bus.iBusClock};
      sel_sync  <= {sel_sync[SYNC_STAGES-2:0], bus.iBusSelect};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.iBusMOSI};
      clk_prev  <= clk_s;
      sel_prev  <= sel_s;
    end
  end

  assign clk_s    = clk_sync[SYNC_STAGES-1];
  assign sel_s    = sel_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign clk_rise = clk_s & ~clk_prev;
  assign clk_fall = ~clk_s & clk_prev;
  assign sel_fall = ~sel_s & sel_prev;

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) state <= IDLE;
    else         state <= state_next;
  end

  // NOTE: state_next gets its default first so no path through the case can infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    ;
      CMD:     if (clk_rise) state_next = mosi_s[7] ? WDATA : RFETCH;
      WDATA:   if (clk_rise && byte_cnt == 2'd3) state_next = DONE;
      RFETCH:  if (!oLocalRead) state_next = RDATA;
      RDATA:   if (clk_rise && byte_cnt == 2'd3) state_next = DONE;
      DONE:    ;
      default: state_next = IDLE;
    endcase
    if (wd_hit) state_next = DONE;
    // A fresh select edge restarts from CMD even on the cycle an abort lands in IDLE.
    if (sel_fall)   state_next = CMD;
    else if (sel_s) state_next = IDLE;
  end

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      byte_cnt          <= '0;
      oLocalAddress     <= '0;
      oLocalWriteData   <= '0;
      rdata             <= '0;
      miso_q            <= '0;
      oLocalWrite       <= 1'b0;
      oLocalRead        <= 1'b0;
      bus.oBusInterrupt <= 1'b0;
    end else begin
      oLocalWrite       <= (state == WDATA) && (state_next == DONE) && clk_rise;
      oLocalRead        <= (state == CMD) && (state_next == RFETCH);
      bus.oBusInterrupt <= iLocalInterrupt;
      if (state_next == IDLE || sel_fall) begin
        byte_cnt <= '0;
        miso_q   <= '0;
      end else begin
        unique case (state)
          CMD:    if (clk_rise) oLocalAddress <= mosi_s[3:0];
          WDATA:  if (clk_rise) begin
                    oLocalWriteData <= {oLocalWriteData[23:0], mosi_s};
                    byte_cnt        <= byte_cnt + 2'd1;
                  end
          RFETCH: if (state_next == RDATA) rdata <= iLocalReadData;
          RDATA:  begin
                    // byte_cnt counts bytes already sampled; ~byte_cnt picks byte 3 down to 0.
                    if (clk_fall) miso_q   <= rdata[{~byte_cnt, 3'b000} +: 8];
                    if (clk_rise) byte_cnt <= byte_cnt + 2'd1;
                  end
          default: ;
        endcase
      end
    end
  end

  assign miso_val = (state == DONE) ? 8'h00 : miso_q;
  assign oBusMISO = (state == IDLE) ? 8'bz : miso_val;

`ifdef SYSX_SLAVE_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            wd_run;

  assign wd_run = !sel_s && (state != IDLE) && !(clk_rise || clk_fall);
  assign wd_hit = wd_run && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  // The count saturates at the limit so a stalled block pulses only once per select.
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      wd_cnt   <= '0;
      oTimeout <= 1'b0;
    end else begin
      oTimeout <= wd_hit;
      if (!wd_run)                                 wd_cnt <= '0;
      else if (wd_cnt != WD_W'(TIMEOUT_CYCLES))    wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  assign wd_hit   = 1'b0;
  assign oTimeout = 1'b0;
`endif

endmodule

// File: tb/tb_sysx_slave.sv
// Directed bench for sysx_slave: a transaction table plus abort, back-to-back, reset,
// interrupt and stall sequences. MISO is pulled up so an undriven lane reads 8'hFF.
module tb_sysx_slave;
  localparam int HALF = 5;   // iClock cycles per bus-clock half period
  localparam int LAT  = 3;   // bus edge to local strobe, with two sync stages

  typedef struct {
    logic        exp_write;
    logic [7:0]  cmd;
    logic [31:0] data;
    logic [3:0]  exp_addr;
  } vec_t;

  logic        iClock = 1'b0;
  logic        iReset;
  tri1  [7:0]  miso;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic        wr, rd, tmo;
  logic [31:0] iLocalReadData;
  logic        iLocalInterrupt;
  logic [31:0] rd_value;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int rise_cyc;
  int wr_cnt = 0, rd_cnt = 0, to_cnt = 0;
  int wr_cyc, rd_cyc;
  logic [3:0]  wr_addr, rd_addr;
  logic [31:0] wr_data;

  vec_t vecs [6];

  sysx_slave_if bus ();

  sysx_slave #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(16)) dut (
    .iClock          (iClock),
    .iReset          (iReset),
    .bus             (bus.slave),
    .oBusMISO        (miso),
    .oLocalAddress   (addr),
    .oLocalWriteData (wdata),
    .oLocalWrite     (wr),
    .oLocalRead      (rd),
    .iLocalReadData  (iLocalReadData),
    .iLocalInterrupt (iLocalInterrupt),
    .oTimeout        (tmo)
  );

  always #5 iClock = ~iClock;
  always @(posedge iClock) cyc++;

  always @(negedge iClock) begin
    if (wr)  begin wr_cnt++; wr_addr = addr; wr_data = wdata; wr_cyc = cyc; end
    if (rd)  begin rd_cnt++; rd_addr = addr; rd_cyc = cyc; end
    if (tmo) to_cnt++;
  end

  // Local device: read data is valid only in the cycle after the read strobe.
  initial begin
    iLocalReadData = 32'hBAD0_BAD0;
    forever begin
      @(negedge iClock);
      if (rd) begin
        @(posedge iClock); #1 iLocalReadData = rd_value;
        @(posedge iClock); #1 iLocalReadData = 32'hBAD0_BAD0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge iClock);
    #1;
  endtask

  // One bus byte: MOSI set while the clock is low, MISO sampled as the clock rises.
  task automatic bus_byte(input logic [7:0] mosi, output logic [7:0] miso_at_rise);
    bus.iBusMOSI = mosi;
    wait_cycles(HALF);
    miso_at_rise  = miso;
    bus.iBusClock = 1'b1;
    rise_cyc      = cyc;
    wait_cycles(HALF);
    bus.iBusClock = 1'b0;
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    logic [7:0] m;
    int w0, r0, cmd_rise, last_rise;
    w0 = wr_cnt; r0 = rd_cnt; rd_value = v.data;
    bus.iBusSelect = 1'b0;
    wait_cycles(HALF);
    bus_byte(v.cmd, m);
    cmd_rise = rise_cyc;
    check({tag, " miso during cmd"}, 32'(m), 32'h00);
    for (int i = 0; i < 4; i++) begin
      bus_byte(v.exp_write ? v.data[31-8*i -: 8] : 8'h00, m);
      if (!v.exp_write) check($sformatf("%s miso byte%0d", tag, 3 - i), 32'(m), 32'(v.data[31-8*i -: 8]));
    end
    last_rise = rise_cyc;
    bus_byte(8'hAA, m);
    check({tag, " miso in done"}, 32'(m), 32'h00);
    bus.iBusSelect = 1'b1;
    wait_cycles(LAT);
    check({tag, " miso z after deselect"}, 32'(miso), 32'hFF);
    check({tag, " write pulses"}, 32'(wr_cnt - w0), v.exp_write ? 32'd1 : 32'd0);
    check({tag, " read pulses"}, 32'(rd_cnt - r0), v.exp_write ? 32'd0 : 32'd1);
    if (v.exp_write) begin
      check({tag, " write addr"}, 32'(wr_addr), 32'(v.exp_addr));
      check({tag, " write data"}, wr_data, v.data);
      check({tag, " write latency"}, 32'(wr_cyc - last_rise), 32'(LAT));
    end else begin
      check({tag, " read addr"}, 32'(rd_addr), 32'(v.exp_addr));
      check({tag, " read latency"}, 32'(rd_cyc - cmd_rise), 32'(LAT));
    end
  endtask

  initial begin
    logic [7:0] m;
    int w0, r0, t0;

    vecs[0] = '{1'b1, 8'h85, 32'hDEAD_BEEF, 4'h5};
    vecs[1] = '{1'b0, 8'h03, 32'h1234_5678, 4'h3};
    vecs[2] = '{1'b1, 8'hF2, 32'h0000_0001, 4'h2};
    vecs[3] = '{1'b0, 8'h7F, 32'hA5C3_0F96, 4'hF};
    vecs[4] = '{1'b1, 8'h80, 32'hFFFF_FFFF, 4'h0};
    vecs[5] = '{1'b0, 8'h0C, 32'h8000_0001, 4'hC};

    iReset = 1'b0; iLocalInterrupt = 1'b0; rd_value = '0;
    bus.iBusClock = 1'b0; bus.iBusSelect = 1'b1; bus.iBusMOSI = 8'h00;
    wait_cycles(3);
    check("reset miso z", 32'(miso), 32'hFF);
    check("reset addr", 32'(addr), 32'h0);
    check("reset wdata", wdata, 32'h0);
    check("reset strobes", {29'd0, wr, rd, tmo}, 32'h0);
    iReset = 1'b1;
    wait_cycles(2);

    // Interrupt is registered once.
    iLocalInterrupt = 1'b1;
    @(negedge iClock);
    check("irq before edge", 32'(bus.oBusInterrupt), 32'h0);
    wait_cycles(1);
    check("irq after edge", 32'(bus.oBusInterrupt), 32'h1);
    iLocalInterrupt = 1'b0;
    wait_cycles(1);
    check("irq cleared", 32'(bus.oBusInterrupt), 32'h0);

    for (int i = 0; i < 6; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Abort a write after two data bytes.
    w0 = wr_cnt;
    bus.iBusSelect = 1'b0;
    wait_cycles(HALF);
    bus_byte(8'h81, m);
    bus_byte(8'h11, m);
    bus_byte(8'h22, m);
    bus.iBusSelect = 1'b1;
    wait_cycles(LAT);
    check("abort miso z", 32'(miso), 32'hFF);
    wait_cycles(HALF);
    check("abort no write", 32'(wr_cnt - w0), 32'h0);
    run_txn('{1'b1, 8'h81, 32'h0BAD_F00D, 4'h1}, "after abort");

    // Back-to-back writes with a one-cycle deselect in between.
    w0 = wr_cnt;
    bus.iBusSelect = 1'b0;
    wait_cycles(HALF);
    bus_byte(8'h84, m);
    for (int i = 0; i < 4; i++) bus_byte(8'h11 * 8'(i + 1), m);
    bus.iBusSelect = 1'b1;
    wait_cycles(1);
    bus.iBusSelect = 1'b0;
    wait_cycles(HALF);
    bus_byte(8'h86, m);
    for (int i = 0; i < 4; i++) bus_byte(8'h11 * 8'(i + 5), m);
    bus.iBusSelect = 1'b1;
    wait_cycles(HALF);
    check("b2b write pulses", 32'(wr_cnt - w0), 32'd2);
    check("b2b second addr", 32'(wr_addr), 32'h6);
    check("b2b second data", wr_data, 32'h5566_7788);

    // Reset pulled during RDATA.
    w0 = wr_cnt; r0 = rd_cnt; rd_value = 32'hCAFE_F00D;
    iLocalInterrupt = 1'b1;
    bus.iBusSelect = 1'b0;
    wait_cycles(HALF);
    bus_byte(8'h03, m);
    bus_byte(8'h00, m);
    check("pre-reset miso", 32'(m), 32'hCA);
    check("pre-reset irq", 32'(bus.oBusInterrupt), 32'h1);
    iReset = 1'b0;
    #1;
    check("mid-reset miso z", 32'(miso), 32'hFF);
    check("mid-reset irq", 32'(bus.oBusInterrupt), 32'h0);
    check("mid-reset addr", 32'(addr), 32'h0);
    check("mid-reset wdata", wdata, 32'h0);
    check("mid-reset strobes", {29'd0, wr, rd, tmo}, 32'h0);
    bus.iBusSelect = 1'b1; iLocalInterrupt = 1'b0;
    wait_cycles(3);
    iReset = 1'b1;
    wait_cycles(3);
    check("reset discards txn", 32'(wr_cnt - w0) + 32'(rd_cnt - r0), 32'd1);
    run_txn(vecs[1], "after reset");

    // Select held with no bus clock.
    w0 = wr_cnt; r0 = rd_cnt; t0 = to_cnt;
    bus.iBusSelect = 1'b0;
    wait_cycles(16);
    check("no early timeout", 32'(to_cnt - t0), 32'h0);
    wait_cycles(24);
`ifdef SYSX_SLAVE_TIMEOUT_EN
    check("one timeout pulse", 32'(to_cnt - t0), 32'd1);
    bus_byte(8'h85, m);
    check("miso after timeout", 32'(m), 32'h00);
    for (int i = 0; i < 4; i++) bus_byte(8'hC0 + 8'(i), m);
    wait_cycles(HALF);
    check("no write after timeout", 32'(wr_cnt - w0), 32'h0);
    check("no read after timeout", 32'(rd_cnt - r0), 32'h0);
`else
    check("timeout stays low", 32'(to_cnt - t0), 32'h0);
    bus_byte(8'h85, m);
    for (int i = 0; i < 4; i++) bus_byte(8'hC0 + 8'(i), m);
    wait_cycles(HALF);
    check("stalled write completes", 32'(wr_cnt - w0), 32'd1);
    check("stalled write data", wr_data, 32'hC0C1_C2C3);
`endif
    bus.iBusSelect = 1'b1;
    wait_cycles(HALF);
    check("final miso z", 32'(miso), 32'hFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
